// File: rtl/piso_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : piso_tx_pkg
// Brief    : Shared state encoding and bit-ordering helpers for the serial link.
// Revision : 1.0 - initial release
// ============================================================================
package piso_tx_pkg;

    localparam int MAX_WIDTH = 32;
    localparam int IDX_W     = $clog2(MAX_WIDTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Words narrower than MAX_WIDTH are passed zero-extended; width locates the MSB.
    function automatic logic bit_out(input logic [MAX_WIDTH-1:0] sh,
                                     input int unsigned           width,
                                     input logic                  msb_first);
        logic [IDX_W-1:0] w_idx;
        w_idx = IDX_W'(width - 1);
        return msb_first ? sh[w_idx] : sh[0];
    endfunction

    function automatic logic [MAX_WIDTH-1:0] shift_next(input logic [MAX_WIDTH-1:0] sh,
                                                        input logic                  msb_first);
        return msb_first ? (sh << 1) : (sh >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : piso_tx_if
// Brief    : Word intake handshake and serial output bundle of the transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface piso_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] pi;
    logic             pi_valid;
    logic             pi_ready;
    logic             so;
    logic             so_valid;
    logic             so_first;
    logic             busy;

    modport master (
        output pi, pi_valid,
        input  pi_ready, so, so_valid, so_first, busy
    );

    modport slave (
        input  pi, pi_valid,
        output pi_ready, so, so_valid, so_first, busy
    );
endinterface
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
// Module   : piso_tx
// Brief    : Parallel-in serial-out transmitter with a one-word holding buffer.
// Revision : 1.0 - initial release
// ============================================================================
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input wire         clk,
    input wire         rst_n,
    piso_tx_if.slave   bus
);

    localparam int             CNT_W  = $clog2(WIDTH);
    localparam [CNT_W-1:0]     c_LAST = CNT_W'(WIDTH - 1);

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_sh, w_sh_nxt;
    logic [WIDTH-1:0]   r_hold, w_hold_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_hold_full, w_hold_full_nxt;

    logic               w_pi_ready;
    logic               w_accept;
    logic               w_shifting;
    logic [WIDTH-1:0]   w_sh_shifted;

    assign w_pi_ready   = rst_n && !r_hold_full;
    assign w_accept     = bus.pi_valid && w_pi_ready;
    assign w_shifting   = (r_state == SHIFT);
    assign w_sh_shifted = WIDTH'(shift_next(MAX_WIDTH'(r_sh), MSB_FIRST));

    assign bus.pi_ready = w_pi_ready;
    assign bus.so_valid = w_shifting;
    assign bus.so       = w_shifting && bit_out(MAX_WIDTH'(r_sh), WIDTH, MSB_FIRST);
    assign bus.so_first = w_shifting && (r_cnt == '0);
    assign bus.busy     = w_shifting || r_hold_full;

    always_comb begin
        w_state_nxt     = r_state;
        w_sh_nxt        = r_sh;
        w_cnt_nxt       = r_cnt;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_sh_nxt    = bus.pi;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_sh_nxt  = w_sh_shifted;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == c_LAST) begin
                    // A held word outranks a fresh one; ready is low then anyway.
                    w_cnt_nxt = '0;
                    if (r_hold_full) begin
                        w_sh_nxt        = r_hold;
                        w_hold_full_nxt = 1'b0;
                    end else if (w_accept) begin
                        w_sh_nxt = bus.pi;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_accept) begin
                    w_hold_nxt      = bus.pi;
                    w_hold_full_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sh        <= '0;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sh        <= w_sh_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out transmitter with valid/ready word intake and a one-word holding buffer. It accepts WIDTH-bit parallel words from an upstream register stage and shifts them out one bit per clock, with a first-bit marker. Back-to-back words stream with no idle gap. A matching serial-in/parallel-out receiver reassembles the words at the other end of the link.

## Interface
- WIDTH, 4, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is transmitted first; 0 = bit 0 is transmitted first.

- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- pi  input  WIDTH  parallel word to transmit.
- pi_valid  input  1  pi holds a word to transmit.
- pi_ready  output  1  block can accept a word this cycle.
- so  output  1  serial data bit.
- so_valid  output  1  so carries a valid bit this cycle.
- so_first  output  1  so is the first bit of a word; only asserted with so_valid.
- busy  output  1  shifter or holding buffer occupied.

## Operation
- Storage:
  - shift register sh[WIDTH-1:0]
  - bit counter cnt, $clog2(WIDTH) bits
  - holding register hold[WIDTH-1:0] with flag hold_full
  - state register: IDLE or SHIFT
- Accept: a word is accepted on an edge where pi_valid && pi_ready && rst_n.
- pi_ready = rst_n && !hold_full (combinational).
- IDLE:
  - On accept, load pi into sh, set cnt=0, go to SHIFT.
  - hold_full stays 0.
- SHIFT:
  - so_valid=1 every cycle.
  - so = sh[WIDTH-1] when MSB_FIRST, else sh[0].
  - so_first = (cnt==0).
  - Each edge shifts sh toward the output end and increments cnt.
- Last-bit edge (cnt==WIDTH-1), evaluated in priority order:
  1. If hold_full, move hold into sh, clear hold_full, set cnt=0, stay in SHIFT.
  2. Else if an accept occurs on this edge, load pi directly into sh, set cnt=0, stay in SHIFT.
  3. Else go to IDLE.
- Accept during SHIFT on any edge not covered by rule 2 writes hold and sets hold_full.
- Simultaneous last-bit edge with hold_full=1 and pi_valid=1: pi_ready is already 0, so nothing is accepted. hold is promoted to the shifter, and pi_ready rises the next cycle.
- Only one word can ever be pending, so there is no overflow case. Words are never dropped or reordered.
- busy = (state==SHIFT) || hold_full.
- pi is sampled only on accepting edges; it may change freely otherwise.

## Timing
- Reset values (rst_n low at an edge):
  - state=IDLE, sh=0, cnt=0, hold=0, hold_full=0
  - so=0, so_valid=0, so_first=0, busy=0
  - pi_ready=0 while rst_n is low
- Reset mid-word: the current word and any held word are discarded. Outputs take their reset values on that edge. pi_ready returns to 1 in the first cycle rst_n is high.
- Latency: a word accepted at edge k presents its first bit, with so_first=1, in the cycle after edge k. Its last bit appears in the cycle after edge k+WIDTH-1.
- Throughput: one word per WIDTH cycles. so_valid stays continuously high while words are supplied at least every WIDTH cycles.
- In IDLE, so_valid=0 and so=0.

## Structure
- A shared package holds:
  - the state enum: IDLE, SHIFT
  - a function bit_out(sh, MSB_FIRST)
  - a function shift_next(sh, MSB_FIRST)
- The receiver reuses this package.
- No sub-module: the holding buffer and the shifter are small enough to live in one module.

## Test plan
- Single word, WIDTH=4, MSB_FIRST=1, pi=4'b1011 accepted at edge 0 -> cycles 1-4 show so=1,0,1,1 with so_valid=1; so_first=1 only in cycle 1; IDLE and busy=0 from cycle 5.
- Back-to-back: pi_valid held high with 4'hA then 4'h5 -> 8 consecutive valid bits 1,0,1,0,0,1,0,1; so_first in cycles 1 and 5; no gap.
- Hold buffer full: words 4'h1, 4'h2, 4'h3 offered continuously -> pi_ready=0 from the cycle after 4'h2 is accepted until 4'h2 is promoted at the last bit of 4'h1; output order is 1, 2, 3.
- LSB-first: MSB_FIRST=0, pi=4'b0001 -> so=1,0,0,0.
- Reset mid-word: rst_n low during bit 2 of 4'hF with a word held -> next cycle so_valid=0, busy=0, pi_ready=0; after release, new word 4'h6 transmits as 0,1,1,0 with no residue from 4'hF.
- Idle gap: 4'hC, then pi_valid=0 for 3 cycles, then 4'h3 -> so_valid drops for exactly the gap; so_first on the first bit of 4'h3.
